// File: rtl/dro_cell_if.sv
// Pulse-level interface of the DRO cell: the two toggle-encoded inputs
// (set, read clock) and the readout / status signals coming back.
interface dro_cell_if;
   logic       set;
   logic       reset;
   logic       out;
   logic       state;
   logic [1:0] viol;
   logic       err;

   // Driver side: produces set/read pulses, observes the cell.
   modport master (
      output set,
      output reset,
      input  out,
      input  state,
      input  viol,
      input  err
   );

   // Cell side: consumes pulses, produces readout and status.
   modport slave (
      input  set,
      input  reset,
      output out,
      output state,
      output viol,
      output err
   );
endinterface

// File: rtl/dro_cell.sv
// Cycle-accurate model of a single-flux-quantum destructive readout cell.
// Inputs and the output are toggle encoded: every transition is one pulse.
// A set pulse stores a 1; a read pulse emits the stored bit on out after a
// fixed clock-to-out delay and clears the cell. Setup/hold spacing between
// set and read pulses is monitored and reported without changing behaviour.
module dro_cell #(
   parameter int CLK_TO_Q_CYCLES = 2,
   parameter int SETUP_CYCLES    = 1,
   parameter int HOLD_CYCLES     = 1
) (
   input logic       clk,
   input logic       rst_n,
   dro_cell_if.slave bus
);

   // The spacing counters only need to reach the larger of the two windows.
   // At least 1 is kept so that "one cycle since the event" is representable.
   localparam int MAX_WIN = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
   localparam int SAT     = (MAX_WIN < 1) ? 1 : MAX_WIN;
   localparam int CW      = $clog2(SAT + 1);

   localparam logic [CW-1:0] SAT_L   = CW'(SAT);
   localparam logic [CW-1:0] ONE_L   = CW'(1);
   localparam logic [CW-1:0] SETUP_L = CW'(SETUP_CYCLES);
   localparam logic [CW-1:0] HOLD_L  = CW'(HOLD_CYCLES);

   logic          set_q;
   logic          reset_q;
   logic          set_p;
   logic          rd_p;
   logic          state_q;
   logic          state_d;
   logic          inject;
   logic          tap;
   logic          out_q;
   logic [CW-1:0] since_set;
   logic [CW-1:0] since_rd;
   logic [CW-1:0] since_set_eff;
   logic          setup_v;
   logic          hold_v;
   logic [1:0]    viol_q;
   logic          err_q;

   // Pulse detection, next stored bit and violation detection for this cycle.
   always_comb begin
      set_p         = bus.set ^ set_q;
      rd_p          = bus.reset ^ reset_q;
      inject        = rd_p & state_q;
      state_d       = state_q;
      since_set_eff = since_set;
      setup_v       = 1'b0;
      hold_v        = 1'b0;

      if (set_p) begin
         state_d = 1'b1;
      end else if (rd_p) begin
         state_d = 1'b0;
      end

      if (set_p) begin
         since_set_eff = '0;
      end

      setup_v = rd_p && (since_set_eff < SETUP_L);
      hold_v  = set_p && !rd_p && (since_rd < HOLD_L);
   end

   // Input history for edge detection plus the stored bit itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_q   <= 1'b0;
         reset_q <= 1'b0;
         state_q <= 1'b0;
      end else begin
         set_q   <= bus.set;
         reset_q <= bus.reset;
         state_q <= state_d;
      end
   end

   // Cycles since the last set pulse; an event restarts it so the next cycle reads 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         since_set <= SAT_L;
      end else if (set_p) begin
         since_set <= ONE_L;
      end else if (since_set < SAT_L) begin
         since_set <= since_set + ONE_L;
      end
   end

   // Cycles since the last read pulse, same saturating behaviour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         since_rd <= SAT_L;
      end else if (rd_p) begin
         since_rd <= ONE_L;
      end else if (since_rd < SAT_L) begin
         since_rd <= since_rd + ONE_L;
      end
   end

   // Clock-to-out delay line. The out toggle flop is the final stage, so
   // only CLK_TO_Q_CYCLES-1 plain stages sit in front of it.
   generate
      if (CLK_TO_Q_CYCLES == 1) begin : g_direct
         assign tap = inject;
      end else begin : g_line
         logic [CLK_TO_Q_CYCLES-2:0] line;

         // Shift in-flight readout pulses one stage per cycle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               line <= '0;
            end else begin
               line[0] <= inject;
               for (int i = 1; i < CLK_TO_Q_CYCLES - 1; i++) begin
                  line[i] <= line[i-1];
               end
            end
         end

         assign tap = line[CLK_TO_Q_CYCLES-2];
      end
   endgenerate

   // Output toggles once for each pulse leaving the delay line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= 1'b0;
      end else if (tap) begin
         out_q <= ~out_q;
      end
   end

   // One-cycle violation strobes and the sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         viol_q <= 2'b00;
         err_q  <= 1'b0;
      end else begin
         viol_q <= {hold_v, setup_v};
         err_q  <= err_q | setup_v | hold_v;
      end
   end

   assign bus.out   = out_q;
   assign bus.state = state_q;
   assign bus.viol  = viol_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_dro_cell.sv
// Directed bench for dro_cell: three instances with different delay/hold
// settings share one clock and reset; each scenario drives one of them.
module tb_dro_cell;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   dro_cell_if if_def ();
   dro_cell_if if_hold ();
   dro_cell_if if_c4 ();

   dro_cell u_def (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_def.slave)
   );

   dro_cell #(.HOLD_CYCLES(3)) u_hold (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_hold.slave)
   );

   dro_cell #(.CLK_TO_Q_CYCLES(4)) u_c4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_c4.slave)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
      end
   endtask

   // Toggle the selected lines of one instance: 0 = default, 1 = hold 3, 2 = delay 4.
   task automatic applyStimulus(input int which, input bit doSet, input bit doRead);
      case (which)
         0: begin
            if (doSet)  if_def.set   = ~if_def.set;
            if (doRead) if_def.reset = ~if_def.reset;
         end
         1: begin
            if (doSet)  if_hold.set   = ~if_hold.set;
            if (doRead) if_hold.reset = ~if_hold.reset;
         end
         default: begin
            if (doSet)  if_c4.set   = ~if_c4.set;
            if (doRead) if_c4.reset = ~if_c4.reset;
         end
      endcase
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic zeroInputs();
      if_def.set  = 1'b0;  if_def.reset  = 1'b0;
      if_hold.set = 1'b0;  if_hold.reset = 1'b0;
      if_c4.set   = 1'b0;  if_c4.reset   = 1'b0;
   endtask

   // Reset every instance with all input lines parked low.
   task automatic resetAll();
      rst_n = 1'b0;
      zeroInputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   // Directed scenario sequence.
   initial begin
      rst_n = 1'b0;
      zeroInputs();
      resetAll();

      // Reset values on all instances
      checkOutput("rst_def_out",   if_def.out,   0);
      checkOutput("rst_def_state", if_def.state, 0);
      checkOutput("rst_def_viol",  if_def.viol,  0);
      checkOutput("rst_def_err",   if_def.err,   0);
      checkOutput("rst_hold_state", if_hold.state, 0);
      checkOutput("rst_c4_out",    if_c4.out,    0);

      // Two sets then two reads, 10 cycles apart
      $display("[TB] basic set/read sequence");
      applyStimulus(0, 1, 0);
      tick();
      checkOutput("basic_state_set1", if_def.state, 1);
      waitCycles(10);
      applyStimulus(0, 1, 0);
      tick();
      checkOutput("basic_state_set2", if_def.state, 1);
      checkOutput("basic_viol_set2",  if_def.viol,  0);
      waitCycles(10);
      applyStimulus(0, 0, 1);
      tick();
      checkOutput("basic_state_rd1", if_def.state, 0);
      checkOutput("basic_out_rd1_c1", if_def.out, 0);
      tick();
      checkOutput("basic_out_rd1_c2", if_def.out, 1);
      waitCycles(10);
      applyStimulus(0, 0, 1);
      waitCycles(4);
      checkOutput("basic_out_final",   if_def.out,   1);
      checkOutput("basic_state_final", if_def.state, 0);
      checkOutput("basic_err_final",   if_def.err,   0);

      // Read of an empty cell
      $display("[TB] read of empty cell");
      applyStimulus(2, 0, 1);
      tick();
      checkOutput("empty_state", if_c4.state, 0);
      checkOutput("empty_viol",  if_c4.viol,  0);
      waitCycles(5);
      checkOutput("empty_out", if_c4.out, 0);
      checkOutput("empty_err", if_c4.err, 0);

      // Same-cycle set and read with a stored 1
      $display("[TB] coincident set and read");
      resetAll();
      applyStimulus(0, 1, 0);
      tick();
      waitCycles(2);
      applyStimulus(0, 1, 1);
      tick();
      checkOutput("coin_viol_strobe", if_def.viol,  2'b01);
      checkOutput("coin_err",         if_def.err,   1);
      checkOutput("coin_state",       if_def.state, 1);
      checkOutput("coin_out_c1",      if_def.out,   0);
      tick();
      checkOutput("coin_out_c2",      if_def.out,   1);
      checkOutput("coin_viol_clear",  if_def.viol,  2'b00);
      checkOutput("coin_err_sticky",  if_def.err,   1);

      // Set one cycle after a read, hold window of 3
      $display("[TB] hold violation");
      resetAll();
      applyStimulus(1, 1, 0);
      tick();
      waitCycles(3);
      applyStimulus(1, 0, 1);
      tick();
      checkOutput("hold_viol_none", if_hold.viol, 2'b00);
      applyStimulus(1, 1, 0);
      tick();
      checkOutput("hold_viol_strobe", if_hold.viol,  2'b10);
      checkOutput("hold_state",       if_hold.state, 1);
      checkOutput("hold_err",         if_hold.err,   1);
      checkOutput("hold_out",         if_hold.out,   1);
      tick();
      checkOutput("hold_viol_clear", if_hold.viol, 2'b00);
      waitCycles(5);
      checkOutput("hold_err_sticky", if_hold.err, 1);
      resetAll();
      checkOutput("hold_err_cleared", if_hold.err, 0);

      // Three back-to-back set+read pairs through a 4-cycle delay line
      $display("[TB] pipelined reads");
      applyStimulus(2, 1, 0);
      tick();
      waitCycles(2);
      applyStimulus(2, 1, 1);
      tick();
      checkOutput("pipe_out_e0", if_c4.out, 0);
      applyStimulus(2, 1, 1);
      tick();
      applyStimulus(2, 1, 1);
      tick();
      checkOutput("pipe_out_e2", if_c4.out, 0);
      tick();
      checkOutput("pipe_out_e3", if_c4.out, 1);
      tick();
      checkOutput("pipe_out_e4", if_c4.out, 0);
      tick();
      checkOutput("pipe_out_e5", if_c4.out, 1);
      waitCycles(3);
      checkOutput("pipe_out_final", if_c4.out,   1);
      checkOutput("pipe_state",     if_c4.state, 1);

      // Reset while a readout pulse is in flight
      $display("[TB] reset with pulse in flight");
      resetAll();
      applyStimulus(0, 1, 0);
      tick();
      waitCycles(2);
      applyStimulus(0, 0, 1);
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("inflight_out_async",   if_def.out,   0);
      checkOutput("inflight_state_async", if_def.state, 0);
      zeroInputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      waitCycles(4);
      checkOutput("inflight_out_after",   if_def.out,   0);
      checkOutput("inflight_state_after", if_def.state, 0);
      checkOutput("inflight_err_after",   if_def.err,   0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dro_cell.md
# dro_cell

Synchronous digital model of a single-flux-quantum destructive readout (DRO) cell. A `set` pulse stores one bit. A `reset` (read-clock) pulse reads the bit out as an `out` pulse and clears the cell. All pulses are toggle-encoded: each transition of a line is one pulse. The block sits in SFQ logic models as the basic storage/delay element, and adds cycle-accurate clock-to-out delay and setup/hold violation checking.

## Interface
Parameters:
- `CLK_TO_Q_CYCLES`, default 2: clk cycles from read-pulse detection to the `out` toggle; legal range 1..15.
- `SETUP_CYCLES`, default 1: minimum clk cycles from a set pulse to the next read pulse.
- `HOLD_CYCLES`, default 1: minimum clk cycles from a read pulse to the next set pulse.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `set`, input, 1: toggle-encoded set pulse, synchronous to `clk`.
- `reset`, input, 1: toggle-encoded read-clock pulse, synchronous to `clk`. This is not a design reset.
- `out`, output, 1: toggle-encoded readout pulse.
- `state`, output, 1: current stored bit.
- `viol`, output, 2: one-cycle strobes; [0] = setup violation, [1] = hold violation.
- `err`, output, 1: sticky OR of all violations; cleared only by `rst_n`.

## Operation
- Pulse detect:
  - `set_p = set ^ set_q`; `rd_p = reset ^ reset_q`.
  - `set_q` and `reset_q` are registered copies of the inputs and reset to 0.
- Set: `set_p` sets `state` to 1. A set while already 1 is absorbed: state stays 1, no error.
- Read: `rd_p` with `state == 1`:
  - injects one pulse into the output delay line;
  - clears `state` to 0.
- Read with `state == 0`: no output pulse, state unchanged.
- Simultaneous `set_p` and `rd_p` in the same cycle:
  - the read sees the old state, so an output pulse is emitted iff old state was 1;
  - `state` ends at 1.
- Output delay line:
  - shift register of `CLK_TO_Q_CYCLES` stages;
  - `out` toggles in the cycle a pulse exits;
  - back-to-back reads pipeline without loss.
- Violation counters:
  - `since_set` and `since_rd` count cycles since the last `set_p` or `rd_p`;
  - each saturates at max(SETUP_CYCLES, HOLD_CYCLES);
  - after reset both start saturated, so the first events never flag.
- Setup violation: `rd_p` while `since_set < SETUP_CYCLES`. A same-cycle set counts as 0.
- Hold violation: `set_p` while `since_rd < HOLD_CYCLES`. A same-cycle coincidence flags setup only.
- Violations are reported only; functional behaviour is unchanged.

## Timing
- Reset values:
  - `out` = 0, `state` = 0, `viol` = 0, `err` = 0;
  - delay line empty; `set_q` = `reset_q` = 0; counters saturated.
- Reset mid-operation discards in-flight output pulses immediately, asynchronously.
- Latency:
  - `state` updates 1 cycle after the input edge is sampled;
  - `out` toggles `CLK_TO_Q_CYCLES` cycles after the cycle in which `rd_p` is detected.
- `viol` strobes are registered, asserted in the cycle after detection, for 1 cycle. `err` rises in that same cycle.
- Minimum pulse spacing is 1 cycle per input; consecutive toggles are consecutive pulses.

## Test plan
- After reset, toggle `set` twice, then `reset` twice, spaced 10 cycles apart:
  - `state` = 1 after the first set;
  - first read toggles `out` 0→1 after 2 cycles;
  - second read produces nothing;
  - final `out` = 1, `err` = 0.
- Read with empty cell: `reset` toggle only -> `out` stays 0, `state` 0, `viol` 0.
- Same-cycle set and read with state = 1:
  - `out` toggles after `CLK_TO_Q_CYCLES`;
  - `state` = 1;
  - `viol[0]` strobes, `err` = 1.
- Set one cycle after a read with HOLD_CYCLES = 3 -> `viol[1]` strobes once, `state` = 1, `err` sticky until `rst_n`.
- Three set+read pairs in consecutive cycles with CLK_TO_Q_CYCLES = 4 -> three `out` toggles at the same relative spacing; final `out` = 1.
- Assert `rst_n` low 1 cycle after a read with a pulse in flight -> `out` stays 0, the pulse is lost, `state` = 0.
